// File: rtl/dma_wb_initiator.sv
// Wishbone-classic DMA initiator: moves blocks of 32-bit words between the SDRAM
// burst window and on-chip streams (read via a small FIFO, write via a holding register).
module dma_wb_initiator #(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic [22:0]      base_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dma_fun_sel,
    output logic             dma_wbs_cyc_o,
    output logic             dma_wbs_stb_o,
    output logic             dma_wbs_we_o,
    output logic [31:0]      dma_wbs_adr_o,
    output logic [31:0]      dma_wbs_dat_o,
    input  logic [31:0]      dma_wbs_dat_i,
    input  logic             dma_wbs_ack_i,
    input  logic             dma_brust_valid_i,
    output logic [31:0]      m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    input  logic [31:0]      s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, RD, WR, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic [LEN_W-1:0] remaining, remaining_nx;
    logic [31:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count, count_nx;
    logic             beat, last_beat, push, pop, s_fire;

    assign beat         = dma_wbs_cyc_o & dma_wbs_stb_o & (dma_wbs_ack_i | dma_brust_valid_i);
    assign last_beat    = beat && (remaining == LEN_W'(1));
    assign push         = (state == RD) && beat;
    assign pop          = m_tvalid && m_tready;
    assign remaining_nx = remaining - LEN_W'(beat);
    assign count_nx     = count + CW'(push) - CW'(pop);

    assign m_tvalid = (count != '0);
    assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;
    // In WR the strobe doubles as the holding-register valid flag.
    assign s_tready = (state == WR) && !dma_wbs_stb_o;
    assign s_fire   = s_tvalid && s_tready;
    assign busy     = (state == RD) || (state == WR) || (state == DRAIN);
    assign done     = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (len == '0) ? DONE : (dir ? WR : RD);
            RD:      if (last_beat) state_nx = DRAIN;
            WR:      if (last_beat) state_nx = DONE;
            DRAIN:   if (count == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            remaining     <= '0;
            dma_fun_sel   <= 2'b00;
            dma_wbs_cyc_o <= 1'b0;
            dma_wbs_stb_o <= 1'b0;
            dma_wbs_we_o  <= 1'b0;
            dma_wbs_adr_o <= '0;
            dma_wbs_dat_o <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start && len != '0) begin
                    remaining     <= len;
                    dma_wbs_adr_o <= {9'h0F0, base_addr & 23'h7FFFFC};
                    dma_wbs_cyc_o <= 1'b1;
                    dma_wbs_stb_o <= !dir;
                    dma_wbs_we_o  <= dir;
                    dma_fun_sel   <= dir ? 2'b10 : 2'b01;
                end
                RD: begin
                    if (beat) begin
                        dma_wbs_adr_o[22:0] <= dma_wbs_adr_o[22:0] + 23'd4;
                        remaining           <= remaining_nx;
                    end
                    // Only request a word when the FIFO is guaranteed room for it.
                    dma_wbs_stb_o <= (remaining_nx != '0) && (count_nx < DEPTH_C);
                    if (last_beat) dma_wbs_cyc_o <= 1'b0;
                end
                WR: begin
                    if (s_fire) begin
                        dma_wbs_dat_o <= s_tdata;
                        dma_wbs_stb_o <= 1'b1;
                    end
                    if (beat) begin
                        dma_wbs_adr_o[22:0] <= dma_wbs_adr_o[22:0] + 23'd4;
                        remaining           <= remaining_nx;
                        dma_wbs_stb_o       <= 1'b0;
                    end
                    if (last_beat) dma_wbs_cyc_o <= 1'b0;
                end
                DONE: begin
                    dma_fun_sel   <= 2'b00;
                    dma_wbs_we_o  <= 1'b0;
                    dma_wbs_adr_o <= '0;
                    dma_wbs_dat_o <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dma_wbs_dat_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nx;
        end
    end
endmodule
